// File: rtl/commit_queue_pkg.sv
// Shared types and sizing for the in-order commit queue (ROB) and its slot storage.
// Channel payloads mirror the decoder, execution-unit and retire-side message formats.
package commit_queue_pkg;

  localparam int COMMIT_DEPTH = 64;
  localparam int COMMIT_ID_W  = 8;
  localparam int PC_W         = 16;
  localparam int DATA_W       = 32;

  typedef enum logic {
    CK_WB     = 1'b0,   // register writeback result
    CK_BRANCH = 1'b1    // branch resolution
  } complete_kind_e;

  // One ROB slot: static fields come from decode, data/miss/target from completion.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [4:0]        rd;
    logic              wb_en;
    logic              is_branch;
    logic              notify_only;
    logic              fin;
    logic [DATA_W-1:0] data;
    logic              miss;
    logic [PC_W-1:0]   target;
  } commit_entry_t;

  typedef struct packed {
    logic [COMMIT_ID_W-1:0] commit_id;
    complete_kind_e         kind;
    logic [DATA_W-1:0]      data;
    logic                   miss;
    logic [PC_W-1:0]        target;
  } complete_info_t;

  // The retired message is the whole head slot.
  typedef commit_entry_t commit_info_t;

endpackage

// File: rtl/commit_slot_ram.sv
// Payload storage for the commit queue: full-entry write at enqueue, field update at
// completion, and an asynchronous read of the head slot.
module commit_slot_ram
  import commit_queue_pkg::*;
#(
  parameter int DEPTH = COMMIT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                wr_en,
  input  logic [PTR_W-1:0]    wr_idx,
  input  commit_entry_t       wr_data,
  input  logic                cp_en,
  input  logic [PTR_W-1:0]    cp_idx,
  input  complete_info_t      cp_info,
  input  logic [PTR_W-1:0]    rd_idx,
  output commit_entry_t       rd_data
);

  commit_entry_t slots [DEPTH];

  // NOTE: payload storage has no reset; validity is tracked by the pointers and done bits,
  // so resetting it would only add a reset net to every storage bit for no benefit.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      slots[wr_idx] <= wr_data;
    end
    // The queue never completes the slot it is allocating in the same cycle.
    if (cp_en) begin
      if (cp_info.kind == CK_WB) begin
        slots[cp_idx].data <= cp_info.data;
      end else begin
        slots[cp_idx].miss   <= cp_info.miss;
        slots[cp_idx].target <= cp_info.target;
      end
    end
  end

  assign rd_data = slots[rd_idx];

endmodule

// File: rtl/commit_queue.sv
// In-order commit queue: allocates slots from decode, marks them done on completion,
// retires the head in order, flushes on a mispredicted branch and latches program end.
module commit_queue
  import commit_queue_pkg::*;
#(
  parameter int DEPTH = COMMIT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  // allocation from decode
  input  logic                   commit_entry_en,
  input  commit_entry_t          commit_entry_msg,
  output logic                   commit_entry_reject,
  output logic [COMMIT_ID_W-1:0] commit_id,
  // completion from execution units
  input  logic                   complete_info_en,
  input  complete_info_t         complete_info_msg,
  output logic                   complete_info_reject,
  // retirement to register file / branch predictor
  output logic                   commit_info_en,
  output commit_info_t           commit_info_msg,
  input  logic                   commit_info_reject,
  // control
  output logic                   flash,
  output logic [PC_W-1:0]        flash_pc,
  output logic                   fin
);

  logic [PTR_W:0]   head;
  logic [PTR_W:0]   tail;
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] head_idx;
  logic [PTR_W-1:0] tail_idx;
  logic [PTR_W-1:0] cp_idx;
  logic [PTR_W-1:0] cp_offset;
  logic [DEPTH-1:0] done;
  logic             empty;
  logic             full;
  logic             enq_fire;
  logic             cp_fire;
  logic             commit_fire;
  commit_entry_t    head_entry;

  assign head_idx = head[PTR_W-1:0];
  assign tail_idx = tail[PTR_W-1:0];
  assign count    = tail - head;
  assign empty    = (head == tail);
  assign full     = (head_idx == tail_idx) && (head[PTR_W] != tail[PTR_W]);

  // A completion is live only if its slot lies in [head, tail), measured from head.
  assign cp_idx    = complete_info_msg.commit_id[PTR_W-1:0];
  assign cp_offset = cp_idx - head_idx;

  generate
    if (PTR_W < COMMIT_ID_W) begin : g_id_hi
      logic unused_id_hi;
      assign unused_id_hi = ^complete_info_msg.commit_id[COMMIT_ID_W-1:PTR_W];
    end
  endgenerate

  assign enq_fire    = commit_entry_en & ~full & ~flash;
  assign cp_fire     = complete_info_en & ~flash & ({1'b0, cp_offset} < count);
  assign commit_fire = commit_info_en & ~commit_info_reject;

  assign commit_entry_reject  = full;
  assign complete_info_reject = 1'b0;
  assign commit_id            = COMMIT_ID_W'(tail_idx);

  assign commit_info_en  = ~empty & done[head_idx] & ~flash;
  assign commit_info_msg = head_entry;

  commit_slot_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_slot_ram (
    .clock   (clock),
    .wr_en   (enq_fire),
    .wr_idx  (tail_idx),
    .wr_data (commit_entry_msg),
    .cp_en   (cp_fire),
    .cp_idx  (cp_idx),
    .cp_info (complete_info_msg),
    .rd_idx  (head_idx),
    .rd_data (head_entry)
  );

  // NOTE: reset is synchronous: it is just the highest-priority branch inside the clocked
  // block, so the sensitivity list holds only the clock edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head     <= '0;
      tail     <= '0;
      flash    <= 1'b0;
      flash_pc <= '0;
      fin      <= 1'b0;
    end else if (flash) begin
      // Flush cycle: everything younger than the mispredicted branch is discarded.
      head  <= '0;
      tail  <= '0;
      flash <= 1'b0;
    end else begin
      if (enq_fire) begin
        tail <= tail + 1'b1;
      end
      if (commit_fire) begin
        head <= head + 1'b1;
      end
      flash <= commit_fire & head_entry.miss;
      if (commit_fire && head_entry.miss) begin
        flash_pc <= head_entry.target;
      end
      if (commit_fire && head_entry.fin) begin
        fin <= 1'b1;
      end
    end
  end

  // Allocation and completion never target the same slot, so their order here is moot.
  always_ff @(posedge clock) begin
    if (!reset_n || flash) begin
      done <= '0;
    end else begin
      if (enq_fire) begin
        done[tail_idx] <= commit_entry_msg.notify_only;
      end
      if (cp_fire) begin
        done[cp_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_commit_queue.sv
// Self-checking bench for commit_queue: directed scenarios plus random traffic, all
// compared every cycle against a queue-level reference model of the ROB.
module tb_commit_queue;
  import commit_queue_pkg::*;

  localparam int DEPTH = COMMIT_DEPTH;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic                   commit_entry_en;
  commit_entry_t          commit_entry_msg;
  logic                   commit_entry_reject;
  logic [COMMIT_ID_W-1:0] commit_id;
  logic                   complete_info_en;
  complete_info_t         complete_info_msg;
  logic                   complete_info_reject;
  logic                   commit_info_en;
  commit_info_t           commit_info_msg;
  logic                   commit_info_reject;
  logic                   flash;
  logic [PC_W-1:0]        flash_pc;
  logic                   fin;

  commit_queue dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .commit_entry_en      (commit_entry_en),
    .commit_entry_msg     (commit_entry_msg),
    .commit_entry_reject  (commit_entry_reject),
    .commit_id            (commit_id),
    .complete_info_en     (complete_info_en),
    .complete_info_msg    (complete_info_msg),
    .complete_info_reject (complete_info_reject),
    .commit_info_en       (commit_info_en),
    .commit_info_msg      (commit_info_msg),
    .commit_info_reject   (commit_info_reject),
    .flash                (flash),
    .flash_pc             (flash_pc),
    .fin                  (fin)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // Reference model: the in-flight entries, oldest first, with their done flags.
  typedef struct {
    commit_entry_t e;
    bit            done;
  } m_slot_t;

  m_slot_t         rob[$];
  int              m_head;
  bit              m_flash;
  logic [PC_W-1:0] m_flash_pc;
  bit              m_fin;

  logic [PC_W-1:0] committed_pc[$];
  int              flash_cycles;
  logic [PC_W-1:0] seen_flash_pc;

  function automatic void model_reset();
    rob.delete();
    m_head     = 0;
    m_flash    = 1'b0;
    m_flash_pc = '0;
    m_fin      = 1'b0;
  endfunction

  function automatic void model_step();
    bit            was_full;
    bit            fire;
    int            off;
    commit_entry_t head_e;
    m_slot_t       s;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (m_flash) begin
      rob.delete();
      m_head  = 0;
      m_flash = 1'b0;
      return;
    end
    was_full = (rob.size() == DEPTH);
    fire     = (rob.size() != 0) && rob[0].done && !commit_info_reject;
    head_e   = '0;
    if (rob.size() != 0) head_e = rob[0].e;
    if (complete_info_en) begin
      off = (int'(complete_info_msg.commit_id) % DEPTH - m_head + DEPTH) % DEPTH;
      if (off < rob.size()) begin
        s      = rob[off];
        s.done = 1'b1;
        if (complete_info_msg.kind == CK_WB) begin
          s.e.data = complete_info_msg.data;
        end else begin
          s.e.miss   = complete_info_msg.miss;
          s.e.target = complete_info_msg.target;
        end
        rob[off] = s;
      end
    end
    if (fire) begin
      if (head_e.fin) m_fin = 1'b1;
      if (head_e.miss) begin
        m_flash    = 1'b1;
        m_flash_pc = head_e.target;
      end
      void'(rob.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
    if (commit_entry_en && !was_full) begin
      s.e    = commit_entry_msg;
      s.done = commit_entry_msg.notify_only;
      rob.push_back(s);
    end
  endfunction

  // One clock cycle: settle inputs, compare against the model, advance the model and DUT.
  task automatic tick();
    bit exp_en;
    #1;
    exp_en = !m_flash && (rob.size() != 0) && rob[0].done;
    check("commit_en", commit_info_en, exp_en);
    if (exp_en) check("commit_msg", commit_info_msg, rob[0].e);
    check("commit_id", commit_id, (m_head + rob.size()) % DEPTH);
    check("entry_reject", commit_entry_reject, rob.size() == DEPTH);
    check("flash", flash, m_flash);
    if (m_flash) check("flash_pc", flash_pc, m_flash_pc);
    check("fin", fin, m_fin);
    if (flash) begin
      flash_cycles++;
      seen_flash_pc = flash_pc;
    end
    if (commit_info_en && !commit_info_reject) committed_pc.push_back(commit_info_msg.pc);
    model_step();
    @(posedge clock);
    #1;
  endtask

  function automatic commit_entry_t mk(input logic [PC_W-1:0] pc, input bit br = 1'b0,
                                       input bit notify = 1'b0, input bit fin_b = 1'b0);
    commit_entry_t e;
    e             = '0;
    e.pc          = pc;
    e.rd          = pc[4:0];
    e.wb_en       = !br && !notify;
    e.is_branch   = br;
    e.notify_only = notify;
    e.fin         = fin_b;
    return e;
  endfunction

  task automatic idle();
    commit_entry_en    = 1'b0;
    commit_entry_msg   = '0;
    complete_info_en   = 1'b0;
    complete_info_msg  = '0;
    commit_info_reject = 1'b0;
  endtask

  task automatic do_enq(input commit_entry_t e);
    commit_entry_en  = 1'b1;
    commit_entry_msg = e;
    tick();
    idle();
  endtask

  task automatic do_comp(input int id, input complete_kind_e kind, input logic [31:0] data,
                         input bit miss, input logic [PC_W-1:0] target);
    complete_info_en            = 1'b1;
    complete_info_msg.commit_id = 8'(id);
    complete_info_msg.kind      = kind;
    complete_info_msg.data      = data;
    complete_info_msg.miss      = miss;
    complete_info_msg.target    = target;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  commit_entry_t exp4;
  int            cand[$];
  int            pick;
  int            stale_id;

  initial begin
    idle();
    model_reset();
    flash_cycles  = 0;
    seen_flash_pc = '0;
    reset_n       = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    check("rst_commit_en", commit_info_en, 1'b0);
    check("rst_flash", flash, 1'b0);
    check("rst_flash_pc", flash_pc, 16'h0);
    check("rst_fin", fin, 1'b0);
    check("rst_commit_id", commit_id, 8'd0);
    check("rst_reject", commit_entry_reject, 1'b0);
    check("cp_reject_tied", complete_info_reject, 1'b0);

    // Three ALU entries completed out of order retire in order.
    committed_pc.delete();
    for (int i = 0; i < 3; i++) begin
      check("t1_commit_id", commit_id, 8'(i));
      do_enq(mk(16'h0100 + 16'(i)));
    end
    tick();
    do_comp(2, CK_WB, 32'h22, 1'b0, '0);
    do_comp(0, CK_WB, 32'h00, 1'b0, '0);
    do_comp(1, CK_WB, 32'h11, 1'b0, '0);
    repeat (3) tick();
    check("t1_n_commits", committed_pc.size(), 3);
    check("t1_order0", committed_pc[0], 16'h0100);
    check("t1_order1", committed_pc[1], 16'h0101);
    check("t1_order2", committed_pc[2], 16'h0102);

    // Fill all slots, overflow request is rejected, then wrap after one retire.
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_enq(mk(16'h0200 + 16'(i)));
    #1;
    check("t2_full_reject", commit_entry_reject, 1'b1);
    do_enq(mk(16'h02ff));
    check("t2_tail_held", commit_id, 8'd0);
    check("t2_still_full", commit_entry_reject, 1'b1);
    do_comp(0, CK_WB, 32'h5a5a, 1'b0, '0);
    tick();
    check("t2_after_commit_reject", commit_entry_reject, 1'b0);
    check("t2_wrap_id", commit_id, 8'd0);
    do_enq(mk(16'h0300));
    check("t2_wrap_next_id", commit_id, 8'd1);

    // Mispredicted branch at id 5 flushes younger, already-completed ids 6 and 7.
    do_reset();
    for (int i = 0; i < 8; i++) do_enq(mk(16'h0400 + 16'(i), i == 5));
    committed_pc.delete();
    flash_cycles = 0;
    for (int i = 0; i < 5; i++) do_comp(i, CK_WB, 32'(i), 1'b0, '0);
    do_comp(6, CK_WB, 32'h6, 1'b0, '0);
    do_comp(7, CK_WB, 32'h7, 1'b0, '0);
    do_comp(5, CK_BRANCH, 32'h0, 1'b1, 16'h0123);
    repeat (5) tick();
    check("t3_flash_cycles", flash_cycles, 1);
    check("t3_flash_pc", seen_flash_pc, 16'h0123);
    check("t3_n_commits", committed_pc.size(), 6);
    check("t3_last_commit", committed_pc[committed_pc.size() - 1], 16'h0405);
    check("t3_next_id", commit_id, 8'd0);
    check("t3_empty", commit_info_en, 1'b0);

    // Retire side holds off for three cycles; message and head must stay put.
    do_reset();
    do_enq(mk(16'h0500));
    do_comp(0, CK_WB, 32'hdead, 1'b0, '0);
    exp4      = mk(16'h0500);
    exp4.data = 32'hdead;
    committed_pc.delete();
    for (int i = 0; i < 3; i++) begin
      commit_info_reject = 1'b1;
      #1;
      check("t4_hold_en", commit_info_en, 1'b1);
      check("t4_hold_msg", commit_info_msg, exp4);
      tick();
    end
    commit_info_reject = 1'b0;
    tick();
    check("t4_n_commits", committed_pc.size(), 1);
    check("t4_drained", commit_info_en, 1'b0);

    // notify_only entry retires right behind its completed predecessor.
    do_reset();
    do_enq(mk(16'h0600));
    do_enq(mk(16'h0601, 1'b0, 1'b1));
    committed_pc.delete();
    do_comp(0, CK_WB, 32'h1, 1'b0, '0);
    repeat (3) tick();
    check("t5_n_commits", committed_pc.size(), 2);
    check("t5_second", committed_pc[1], 16'h0601);

    // fin is sticky across later commits, and reset clears everything.
    do_reset();
    do_enq(mk(16'h0700));
    do_enq(mk(16'h0701, 1'b0, 1'b0, 1'b1));
    do_enq(mk(16'h0702));
    for (int i = 0; i < 3; i++) do_comp(i, CK_WB, 32'(i), 1'b0, '0);
    repeat (3) tick();
    check("t6_fin_set", fin, 1'b1);
    do_enq(mk(16'h0703));
    do_comp(3, CK_WB, 32'h3, 1'b0, '0);
    repeat (2) tick();
    check("t6_fin_sticky", fin, 1'b1);
    do_enq(mk(16'h0704));
    do_enq(mk(16'h0705, 1'b0, 1'b1));
    do_reset();
    #1;
    check("t6_rst_fin", fin, 1'b0);
    check("t6_rst_commit_en", commit_info_en, 1'b0);
    check("t6_rst_flash", flash, 1'b0);
    check("t6_rst_flash_pc", flash_pc, 16'h0);
    check("t6_rst_commit_id", commit_id, 8'd0);

    // Random traffic against the model, including stale completions and mispredicts.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      idle();
      if ($urandom_range(0, 99) < 60) begin
        commit_entry_en  = 1'b1;
        commit_entry_msg = mk(16'($urandom), $urandom_range(0, 3) == 0,
                              $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
      end
      cand.delete();
      for (int i = 0; i < rob.size(); i++) if (!rob[i].done) cand.push_back(i);
      if (cand.size() != 0 && $urandom_range(0, 99) < 55) begin
        pick                        = cand[$urandom_range(0, cand.size() - 1)];
        complete_info_en            = 1'b1;
        complete_info_msg.commit_id = 8'((m_head + pick) % DEPTH);
        if (rob[pick].e.is_branch) begin
          complete_info_msg.kind   = CK_BRANCH;
          complete_info_msg.miss   = ($urandom_range(0, 9) == 0);
          complete_info_msg.target = 16'($urandom);
        end else begin
          complete_info_msg.kind = CK_WB;
          complete_info_msg.data = $urandom;
        end
      end else if (rob.size() < DEPTH && $urandom_range(0, 99) < 20) begin
        stale_id                    = (m_head + rob.size() +
                                       $urandom_range(0, DEPTH - 1 - rob.size())) % DEPTH;
        complete_info_en            = 1'b1;
        complete_info_msg.commit_id = 8'(stale_id);
        complete_info_msg.kind      = CK_BRANCH;
        complete_info_msg.miss      = 1'b1;
        complete_info_msg.target    = 16'hbad0;
      end
      commit_info_reject = ($urandom_range(0, 99) < 20);
      tick();
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
